// File: rtl/rbm_seq_pkg.sv
// Shared types for the RBM batch sequencer.
// State encoding, the no-class marker and a width-neutral compare helper.
package rbm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RRST,
    S_RUN,
    S_ARGMAX,
    S_REPORT,
    S_DONE
  } state_t;

  // Slice down to the label width at the use site.
  localparam logic [31:0] CLASS_NONE = '1;

  // Operands arrive already extended to 32 bits by the caller.
  function automatic logic gt_cmp(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sgn
  );
    if (sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/rbm_argmax_seq.sv
// Sequential argmax, one element per cycle, lowest index wins ties.
// Ports: clock, reset(n), start, is_signed, vec -> busy, done, index, max_val.
module rbm_argmax_seq
  import rbm_seq_pkg::*;
#(
  parameter int N  = 10,
  parameter int W  = 12,
  parameter int IW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N*W-1:0] vec,
  output logic           busy,
  output logic           done,
  output logic [IW-1:0]  index,
  output logic [W-1:0]   max_val
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  elems [N];
  logic [CW-1:0] pos;
  logic [IW-1:0] best_idx;
  logic [W-1:0]  best_val;
  logic [W-1:0]  cur;
  logic          take;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign elems[g] = vec[g*W +: W];
  end

  function automatic logic [31:0] ext(
    input logic [W-1:0] v,
    input logic         sgn
  );
    return sgn ? {{(32-W){v[W-1]}}, v}
               : {{(32-W){1'b0}}, v};
  endfunction

  // index/max_val include the element under scan, so on the
  // done cycle they already hold the final answer.
  always_comb begin
    cur  = elems[pos];
    take = busy && ((pos == '0) ||
           gt_cmp(ext(cur, is_signed),
                  ext(best_val, is_signed),
                  is_signed));
    index   = take ? IW'(pos) : best_idx;
    max_val = take ? cur : best_val;
    done    = busy && (pos == CW'(N-1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      pos      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      pos  <= '0;
    end else if (busy) begin
      best_idx <= index;
      best_val <= max_val;
      pos      <= pos + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rbm_batch_sequencer.sv
// Batch controller: feeds images to Main, waits for finish, scores argmax.
// Ports: image source handshake, Main control/data, per-image result, batch counters.
module rbm_batch_sequencer
  import rbm_seq_pkg::*;
#(
  parameter int INPUT_DIM  = 784,
  parameter int OUTPUT_DIM = 10,
  parameter int BITLENGTH  = 12,
  parameter int LABEL_W    = 4,
  parameter int BATCH_SIZE = 16,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            img_valid,
  output logic                            img_ready,
  input  logic [INPUT_DIM-1:0]            img_data,
  input  logic [LABEL_W-1:0]              img_label,
  output logic                            rbm_reset,
  output logic                            rbm_data_valid,
  output logic [INPUT_DIM-1:0]            rbm_input,
  input  logic [OUTPUT_DIM*BITLENGTH-1:0] rbm_output,
  input  logic                            rbm_finish,
  output logic                            result_valid,
  output logic [LABEL_W-1:0]              result_class,
  output logic                            result_hit,
  output logic                            result_timeout,
  output logic [CNT_W-1:0]                image_count,
  output logic [CNT_W-1:0]                correct_count,
  output logic                            busy,
  output logic                            done
);

  localparam int TMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t state, state_next;

  logic [TW-1:0]                     cnt;
  logic                              finish_q;
  logic                              fin_edge;
  logic                              tmo;
  logic                              launch;
  logic                              last;
  logic [CNT_W-1:0]                  img_inc;
  logic [LABEL_W-1:0]                label_q;
  logic [OUTPUT_DIM*BITLENGTH-1:0]   out_q;
  logic                              am_start;
  logic                              am_done;
  logic                              am_busy_unused;
  logic [LABEL_W-1:0]                am_index;
  logic [BITLENGTH-1:0]              am_max_unused;

  // finish_q samples every cycle, so a finish already high on
  // RUN entry is not mistaken for an edge.
  assign fin_edge = rbm_finish && !finish_q;
  assign tmo      = (cnt == TW'(TIMEOUT));
  assign launch   = start && (state == S_IDLE || state == S_DONE);
  assign img_inc  = (image_count == '1) ? image_count
                                        : image_count + CNT_W'(1);
  assign last     = (img_inc == CNT_W'(BATCH_SIZE));
  assign am_start = (state == S_RUN) && fin_edge;

  assign img_ready      = (state == S_FETCH);
  assign rbm_data_valid = (state == S_RUN);
  assign result_valid   = (state == S_REPORT);
  assign done           = (state == S_DONE);
  assign busy           = !(state == S_IDLE || state == S_DONE);
  assign rbm_reset      = (state == S_IDLE) || (state == S_RRST) ||
                          (state == S_DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (img_valid) state_next = S_RRST;
      S_RRST:   if (cnt == TW'(RST_CYCLES-1)) state_next = S_RUN;
      S_RUN: begin
        if (fin_edge) state_next = S_ARGMAX;
        else if (tmo) state_next = S_REPORT;
      end
      S_ARGMAX: if (am_done) state_next = S_REPORT;
      S_REPORT: state_next = last ? S_DONE : S_FETCH;
      S_DONE:   if (start) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // cnt restarts on every state change; RRST and RUN both use it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      finish_q <= 1'b0;
    end else begin
      state    <= state_next;
      finish_q <= rbm_finish;
      if (state_next != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rbm_input      <= '0;
      label_q        <= '0;
      out_q          <= '0;
      result_class   <= '0;
      result_hit     <= 1'b0;
      result_timeout <= 1'b0;
    end else begin
      if (state == S_FETCH && img_valid) begin
        rbm_input <= img_data;
        label_q   <= img_label;
      end
      if (am_start) out_q <= rbm_output;
      if (state == S_RUN && !fin_edge && tmo) begin
        result_class   <= CLASS_NONE[LABEL_W-1:0];
        result_hit     <= 1'b0;
        result_timeout <= 1'b1;
      end
      if (state == S_ARGMAX && am_done) begin
        result_class   <= am_index;
        result_hit     <= (am_index == label_q);
        result_timeout <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      image_count   <= '0;
      correct_count <= '0;
    end else if (launch) begin
      image_count   <= '0;
      correct_count <= '0;
    end else if (state == S_REPORT) begin
      image_count <= img_inc;
      if (result_hit && correct_count != '1)
        correct_count <= correct_count + CNT_W'(1);
    end
  end

  rbm_argmax_seq #(
    .N  (OUTPUT_DIM),
    .W  (BITLENGTH),
    .IW (LABEL_W)
  ) u_argmax (
    .clock     (clock),
    .reset     (reset),
    .start     (am_start),
    .is_signed (1'b1),
    .vec       (out_q),
    .busy      (am_busy_unused),
    .done      (am_done),
    .index     (am_index),
    .max_val   (am_max_unused)
  );

endmodule

// File: tb/tb_rbm_batch_sequencer.sv
// Self-checking bench for rbm_batch_sequencer with a behavioural Main stub.
// Table-driven argmax vectors plus timeout, stall, stale-finish and reset sequences.
module tb_rbm_batch_sequencer;

  localparam int ID = 64;
  localparam int OD = 10;
  localparam int BL = 12;
  localparam int LW = 4;
  localparam int BS = 3;
  localparam int CW = 16;
  localparam int RC = 2;
  localparam int TO = 100;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              img_valid = 1'b0;
  logic              img_ready;
  logic [ID-1:0]     img_data = '0;
  logic [LW-1:0]     img_label = '0;
  logic              rbm_reset;
  logic              rbm_data_valid;
  logic [ID-1:0]     rbm_input;
  logic [OD-1:0][BL-1:0] outv_drv = '0;
  logic              rbm_finish;
  logic              result_valid;
  logic [LW-1:0]     result_class;
  logic              result_hit;
  logic              result_timeout;
  logic [CW-1:0]     image_count;
  logic [CW-1:0]     correct_count;
  logic              busy;
  logic              done;

  always #5 clock = ~clock;

  rbm_batch_sequencer #(
    .INPUT_DIM(ID), .OUTPUT_DIM(OD), .BITLENGTH(BL),
    .LABEL_W(LW), .BATCH_SIZE(BS), .CNT_W(CW),
    .RST_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .img_valid(img_valid), .img_ready(img_ready),
    .img_data(img_data), .img_label(img_label),
    .rbm_reset(rbm_reset), .rbm_data_valid(rbm_data_valid),
    .rbm_input(rbm_input), .rbm_output(outv_drv),
    .rbm_finish(rbm_finish), .result_valid(result_valid),
    .result_class(result_class), .result_hit(result_hit),
    .result_timeout(result_timeout), .image_count(image_count),
    .correct_count(correct_count), .busy(busy), .done(done)
  );

  // Main stub: finish rises 50 cycles after data_valid.
  logic [7:0] scnt;
  logic       sfin;
  logic       stub_never = 1'b0;
  logic       fin_ovr_en = 1'b0;
  logic       fin_ovr = 1'b0;

  always_ff @(posedge clock) begin
    if (rbm_reset || !rbm_data_valid) begin
      scnt <= '0;
      sfin <= 1'b0;
    end else begin
      scnt <= scnt + 8'd1;
      if (scnt == 8'd49) sfin <= 1'b1;
    end
  end

  assign rbm_finish = fin_ovr_en ? fin_ovr : (sfin && !stub_never);

  typedef struct {
    logic [OD-1:0][BL-1:0] outv;
    logic [LW-1:0]         label;
    logic [LW-1:0]         cls;
    logic                  hit;
  } vec_t;

  vec_t tv[6];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [LW-1:0] lab, input logic [ID-1:0] dat);
    int n;
    n = 0;
    img_label = lab;
    img_data  = dat;
    img_valid = 1'b1;
    @(negedge clock);
    while (!img_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("feed_ready", img_ready, 1);
    tick();
    img_valid = 1'b0;
    chk("rbm_input", rbm_input, dat);
  endtask

  task automatic wait_result(input string name, output int dv);
    int n;
    n  = 0;
    dv = 0;
    @(negedge clock);
    while (!result_valid && n < 1000) begin
      if (rbm_data_valid) dv++;
      @(negedge clock);
      n++;
    end
    chk({name, "_valid"}, result_valid, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clock);
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_rbm_reset", rbm_reset, 1);
    tick();
  endtask

  task automatic wait_dv();
    int n;
    n = 0;
    @(negedge clock);
    while (!rbm_data_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("reach_run", rbm_data_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dv;
    logic bad_rr, bad_rdy, bad_rv;

    for (int k = 0; k < 6; k++)
      for (int i = 0; i < OD; i++) tv[k].outv[i] = '0;
    tv[0].outv[0] = 12'd5;
    tv[0].outv[1] = 12'hFFD;
    tv[0].outv[2] = 12'h7FF;
    tv[0].label = 4'd2; tv[0].cls = 4'd2; tv[0].hit = 1'b1;
    tv[1].outv[0] = 12'd7;
    tv[1].outv[1] = 12'd7;
    tv[1].outv[2] = 12'd1;
    tv[1].label = 4'd3; tv[1].cls = 4'd0; tv[1].hit = 1'b0;
    for (int i = 0; i < OD; i++) tv[2].outv[i] = 12'hFE2;
    tv[2].outv[0] = 12'hFFB;
    tv[2].outv[1] = 12'hFFF;
    tv[2].outv[2] = 12'hFF7;
    tv[2].label = 4'd1; tv[2].cls = 4'd1; tv[2].hit = 1'b1;
    tv[3].outv[0] = 12'hFFF;
    tv[3].outv[4] = 12'd3;
    tv[3].label = 4'd4; tv[3].cls = 4'd4; tv[3].hit = 1'b1;
    for (int i = 0; i < OD; i++) tv[4].outv[i] = 12'h800;
    tv[4].outv[9] = 12'h801;
    tv[4].label = 4'd9; tv[4].cls = 4'd9; tv[4].hit = 1'b1;
    tv[5].outv[1] = 12'h7FF;
    tv[5].outv[3] = 12'h7FE;
    tv[5].outv[6] = 12'h7FF;
    tv[5].label = 4'd6; tv[5].cls = 4'd1; tv[5].hit = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rbm_reset", rbm_reset, 1);
    chk("rst_img_ready", img_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_image_count", image_count, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    @(negedge clock);
    chk("idle_rbm_reset", rbm_reset, 1);
    chk("idle_img_ready", img_ready, 0);
    tick();

    // Two batches of table vectors.
    for (int k = 0; k < 6; k++) begin
      if (k % 3 == 0) pulse_start();
      outv_drv = tv[k].outv;
      feed(tv[k].label, ID'(64'hA5A5_0000 + k));
      wait_result($sformatf("vec%0d", k), dv);
      chk($sformatf("vec%0d_class", k), result_class, tv[k].cls);
      chk($sformatf("vec%0d_hit", k), result_hit, tv[k].hit);
      chk($sformatf("vec%0d_timeout", k), result_timeout, 0);
      chk($sformatf("vec%0d_count", k), image_count, k % 3);
      tick();
      if (k % 3 == 2) begin
        wait_done();
        chk("batch_image_count", image_count, 3);
        chk("batch_correct_count", correct_count, 2);
      end
    end

    // Batch 3, image 1: Main never finishes.
    pulse_start();
    chk("new_batch_count", image_count, 0);
    stub_never = 1'b1;
    feed(4'd0, 64'h1234);
    wait_result("tmo", dv);
    chk("tmo_class", result_class, 4'hF);
    chk("tmo_hit", result_hit, 0);
    chk("tmo_flag", result_timeout, 1);
    chk("tmo_run_len", (dv >= TO && dv <= TO + 1), 1);
    tick();
    stub_never = 1'b0;

    // Image 2: source stalls 20 cycles; a stray start is ignored.
    bad_rr = 1'b0;
    bad_rdy = 1'b0;
    bad_rv = 1'b0;
    outv_drv = tv[0].outv;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(negedge clock);
      if (rbm_reset) bad_rr = 1'b1;
      if (!img_ready) bad_rdy = 1'b1;
      if (result_valid) bad_rv = 1'b1;
      tick();
    end
    chk("stall_rbm_reset", bad_rr, 0);
    chk("stall_img_ready", bad_rdy, 0);
    chk("stall_result_valid", bad_rv, 0);
    chk("stall_count_kept", image_count, 1);
    feed(4'd2, 64'h5678);
    wait_result("stall", dv);
    chk("stall_class", result_class, 4'd2);
    chk("stall_hit", result_hit, 1);
    chk("stall_timeout_clr", result_timeout, 0);
    tick();

    // Image 3: finish already high when RUN starts.
    fin_ovr_en = 1'b1;
    fin_ovr = 1'b1;
    outv_drv = tv[3].outv;
    feed(4'd4, 64'h9ABC);
    wait_dv();
    bad_rv = 1'b0;
    bad_rdy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (result_valid) bad_rv = 1'b1;
      if (!rbm_data_valid) bad_rdy = 1'b1;
    end
    chk("stale_no_result", bad_rv, 0);
    chk("stale_still_run", bad_rdy, 0);
    tick();
    fin_ovr = 1'b0;
    tick();
    fin_ovr = 1'b1;
    wait_result("stale", dv);
    chk("stale_class", result_class, 4'd4);
    chk("stale_hit", result_hit, 1);
    tick();
    fin_ovr_en = 1'b0;
    fin_ovr = 1'b0;
    wait_done();
    chk("b3_image_count", image_count, 3);
    chk("b3_correct_count", correct_count, 2);

    // Reset asserted mid-RUN.
    pulse_start();
    outv_drv = tv[4].outv;
    feed(4'd9, 64'hDEAD);
    wait_dv();
    #1 reset = 1'b0;
    #1;
    chk("mid_rbm_reset", rbm_reset, 1);
    chk("mid_data_valid", rbm_data_valid, 0);
    chk("mid_rbm_input", rbm_input, 0);
    chk("mid_busy", busy, 0);
    chk("mid_result_class", result_class, 0);
    chk("mid_result_hit", result_hit, 0);
    chk("mid_img_ready", img_ready, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    pulse_start();
    @(negedge clock);
    chk("post_busy", busy, 1);
    chk("post_count", image_count, 0);
    chk("post_correct", correct_count, 0);
    tick();
    outv_drv = tv[3].outv;
    feed(4'd4, 64'hBEEF);
    wait_result("post", dv);
    chk("post_class", result_class, 4'd4);
    chk("post_hit", result_hit, 1);
    tick();
    @(negedge clock);
    chk("post_count1", image_count, 1);
    chk("post_correct1", correct_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rbm_batch_sequencer.md
Name: rbm_batch_sequencer

Overview:
- Synthesizable batch controller that drives Main over a sequence of images: accepts image/label pairs, pulses Main's reset, asserts data_valid, waits for finish, captures the output vector, computes argmax and scores it against the label.
- Sits between an image source (on-chip ROM or host FIFO) and one Main instance.
- Generalises single-image bring-up to multi-image batches, with classification, accuracy counting and a hang timeout.

Parameters:
- INPUT_DIM, 784, bits per binary image (64 in SPARSE builds).
- OUTPUT_DIM, 10, number of Main output scores.
- BITLENGTH, 12, width of each output score (two's complement).
- LABEL_W, 4, label / class-index width; 2^LABEL_W must be greater than OUTPUT_DIM.
- BATCH_SIZE, 16, images per batch (at least 1).
- CNT_W, 16, width of image and correct counters; 2^CNT_W must be greater than BATCH_SIZE.
- RST_CYCLES, 2, cycles Main's reset is held high per image (at least 1).
- TIMEOUT, 65535, maximum cycles waiting for finish.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a batch when idle.
- img_valid  in  1  source has an image.
- img_ready  out  1  sequencer accepts an image this cycle.
- img_data  in  INPUT_DIM  packed image bits.
- img_label  in  LABEL_W  ground-truth class.
- rbm_reset  out  1  active-high reset to Main.
- rbm_data_valid  out  1  data_valid to Main.
- rbm_input  out  INPUT_DIM  registered image to Main.
- rbm_output  in  OUTPUT_DIM*BITLENGTH  Main's packed OutputDataPort.
- rbm_finish  in  1  Main's finish.
- result_valid  out  1  one-cycle pulse per image.
- result_class  out  LABEL_W  argmax index; all-ones on timeout.
- result_hit  out  1  result_class equals the label.
- result_timeout  out  1  this image timed out.
- image_count  out  CNT_W  images completed in this batch.
- correct_count  out  CNT_W  hits in this batch.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  held high in DONE until the next start.

Behaviour:
- Reset (reset low, asynchronous) clears every output to 0 and puts the FSM in IDLE. Exception: rbm_reset goes to 1 so Main is held in reset while the sequencer is in reset.
- IDLE:
  - img_ready=0, rbm_reset=1.
  - start moves to FETCH and clears image_count, correct_count and done.
- FETCH:
  - img_ready=1.
  - On img_valid&&img_ready, register img_data into rbm_input and img_label into a label register, then go to RRST.
  - Only one image is accepted per FETCH visit.
  - If img_valid stays low, wait indefinitely.
- RRST:
  - rbm_reset=1 for exactly RST_CYCLES cycles, then rbm_reset=0 and go to RUN.
  - rbm_data_valid=0 throughout.
- RUN:
  - rbm_data_valid=1.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - A rising edge of rbm_finish (finish=1 now, 0 in the previous registered sample) latches rbm_output and goes to ARGMAX.
  - If finish is already high on entry, that is not an edge; keep waiting.
  - If the counter reaches TIMEOUT with no edge: result_class=all-ones, result_hit=0, result_timeout=1, go to REPORT.
  - A finish edge and the timeout in the same cycle: the finish edge wins.
- ARGMAX:
  - rbm_data_valid=0.
  - Sequential scan, one element per cycle, index 0 to OUTPUT_DIM-1; takes exactly OUTPUT_DIM cycles.
  - Compare is signed. The max starts at element 0; replace only on strictly greater, so ties go to the lowest index. Inf (0x7FF) is handled as an ordinary value.
  - At the end, result_hit = (class == label) and result_timeout=0.
- REPORT:
  - result_valid=1 for one cycle. image_count+1; correct_count+1 if result_hit.
  - result_class, result_hit and result_timeout hold until the next REPORT.
  - Next state is DONE if the new image_count equals BATCH_SIZE, otherwise FETCH.
- DONE:
  - done=1, rbm_reset=1.
  - start returns to FETCH (new batch, counters cleared).
- start outside IDLE/DONE is ignored.
- Counters saturate at all-ones (unreachable given the parameter constraint).
- Latency per image, counted from the FETCH handshake to result_valid: RST_CYCLES + (cycles to finish edge) + OUTPUT_DIM + 2.

Decomposition:
- Shared package rbm_seq_pkg holds:
  - state encoding (IDLE, FETCH, RRST, RUN, ARGMAX, REPORT, DONE);
  - the CLASS_NONE all-ones constant;
  - the signed-compare helper function.
- One sub-module, rbm_argmax_seq: start/busy/done handshake; inputs are the packed vector and a signed mode; outputs are the index and max value.
- The unpacking of rbm_output uses the existing 1D pack/unpack macros.

Test Plan:
- Batch of 3 with OUTPUT_DIM=10, using a Main stub that raises finish 50 cycles after data_valid. Outputs {5,-3,0x7FF,...} with label 2 -> class 2, hit=1. Then 3 images in total -> correct_count reflects the hits, image_count=3, done=1.
- Tie {7,7,1,...} -> class 0. All-negative {-5,-1,-9,...} -> class 1 (checks the signed compare).
- Stub never raises finish, TIMEOUT=100 -> result_timeout=1, class=0xF, hit=0, and the sequencer moves on to the next image.
- img_valid withheld 20 cycles in FETCH -> rbm_reset stays 0, img_ready stays 1, no result_valid; resumes on valid.
- Finish already high on RUN entry -> no capture until a fresh 0->1 edge.
- reset driven low mid-RUN -> all outputs 0, rbm_reset=1, IDLE. A start after release runs a clean batch with counters at 0.
